// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared constants and helpers for the 4-way round-robin arbiter.
//   NUM_REQ     number of requesters (A..D)
//   SEL_W       width of the encoded selector index
//   IDLE/GRANT  arbiter FSM state encoding
//   onehot_enc  index -> one-hot grant vector
//   onehot_dec  one-hot grant vector -> index
package rr_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  // FSM state encoding {IDLE, GRANT}; kept as plain constants for legacy tools.
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  function automatic logic [NUM_REQ-1:0] onehot_enc(input logic [SEL_W-1:0] idx);
    logic [NUM_REQ-1:0] vec;
    vec = 4'b0000;
    vec[idx] = 1'b1;
    return vec;
  endfunction

  function automatic logic [SEL_W-1:0] onehot_dec(input logic [NUM_REQ-1:0] vec);
    logic [SEL_W-1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (vec[i]) begin
        idx = SEL_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arb_4_1_if.sv
// rr_arb_4_1_if: request/grant bundle between four requesters and the arbiter.
//   req    requesters -> arbiter, one bit per source
//   gnt    arbiter -> requesters, one-hot grant
//   sel    arbiter -> 4:1 selector, encoded grant index
//   valid  arbiter -> consumers, a grant is active
// Modports: master = requester side, slave = arbiter side.
interface rr_arb_4_1_if;

  logic [rr_arb_pkg::NUM_REQ-1:0] req;
  logic [rr_arb_pkg::NUM_REQ-1:0] gnt;
  logic [rr_arb_pkg::SEL_W-1:0]   sel;
  logic                           valid;

  modport master (output req, input gnt, input sel, input valid);
  modport slave  (input req, output gnt, output sel, output valid);

endinterface

// File: rtl/rr_pick.sv
// rr_pick: combinational rotating-priority picker.
//   req     request vector
//   ptr     index given highest priority this decision
//   winner  first requesting index scanning ptr, ptr+1, ... mod 4
//   any     at least one request present
module rr_pick
  import rr_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [SEL_W-1:0]   winner,
  output logic               any
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [SEL_W-1:0]     off;

  // Doubling the vector lets a plain part-select rotate it so bit k is req[ptr+k].
  assign dbl = {req, req};
  assign rot = dbl[ptr +: NUM_REQ];

  // Fixed-priority search on the rotated vector gives the offset from ptr.
  always_comb begin
    off = 2'd0;
    if (rot[0]) begin
      off = 2'd0;
    end else if (rot[1]) begin
      off = 2'd1;
    end else if (rot[2]) begin
      off = 2'd2;
    end else if (rot[3]) begin
      off = 2'd3;
    end else begin
      off = 2'd0;
    end
  end

  // Offset addition wraps naturally in SEL_W bits.
  assign winner = ptr + off;
  assign any    = |req;

endmodule

// File: rtl/rr_arb_4_1.sv
// rr_arb_4_1: four-requester round-robin arbiter driving a 4:1 selector.
//   CLK        rising-edge clock
//   RST        synchronous active-high reset
//   bus.req    request vector (input)
//   bus.gnt    registered one-hot grant, zero when idle
//   bus.sel    registered grant index, holds its value through idle
//   bus.valid  registered, high while a grant is active
// Parameters: MAX_HOLD (1..2^CNT_W-1) caps consecutive grant cycles when the
// owner is re-arbitrated; CNT_W is the hold counter width.
module rr_arb_4_1
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input logic         CLK,
  input logic         RST,
  rr_arb_4_1_if.slave bus
);

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic [0:0]         state;
  logic [SEL_W-1:0]   ptr;
  logic [CNT_W-1:0]   cnt;
  logic [NUM_REQ-1:0] gnt;
  logic [SEL_W-1:0]   sel;
  logic               valid;

  logic               owner_release;
  logic [SEL_W-1:0]   pick_ptr;
  logic [SEL_W-1:0]   win;
  logic               any;

  assign bus.gnt   = gnt;
  assign bus.sel   = sel;
  assign bus.valid = valid;

  // Release when the owner stops asking or has used up its hold budget; on
  // release the picker already sees the advanced pointer so the hand-off
  // happens on the same edge without an idle bubble.
  always_comb begin
    owner_release = 1'b0;
    pick_ptr      = ptr;
    if (state == GRANT) begin
      owner_release = !bus.req[sel] || (cnt == HOLD_LIM);
      if (owner_release) begin
        pick_ptr = sel + 2'd1;
      end else begin
        pick_ptr = ptr;
      end
    end else begin
      owner_release = 1'b0;
      pick_ptr      = ptr;
    end
  end

  rr_pick u_pick (
    .req    (bus.req),
    .ptr    (pick_ptr),
    .winner (win),
    .any    (any)
  );

  // FSM, pointer, hold counter and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      ptr   <= 2'd0;
      cnt   <= CNT_ZERO;
      gnt   <= 4'b0000;
      sel   <= 2'd0;
      valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            state <= GRANT;
            gnt   <= onehot_enc(win);
            sel   <= win;
            valid <= 1'b1;
            cnt   <= CNT_ONE;
          end
        end
        GRANT: begin
          if (!owner_release) begin
            // Cannot pass HOLD_LIM: reaching it forces a release.
            cnt <= cnt + CNT_ONE;
          end else begin
            ptr <= pick_ptr;
            if (any) begin
              gnt <= onehot_enc(win);
              sel <= win;
              cnt <= CNT_ONE;
            end else begin
              state <= IDLE;
              gnt   <= 4'b0000;
              valid <= 1'b0;
              cnt   <= CNT_ZERO;
            end
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= 4'b0000;
          valid <= 1'b0;
          cnt   <= CNT_ZERO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arb_4_1.sv
// tb_rr_arb_4_1: self-checking bench. Three arbiters (MAX_HOLD = 2, 4, 1) share
// clock, reset and request stimulus; a behavioural model pushes expected
// outputs per cycle into a scoreboard that is drained after each edge.
module tb_rr_arb_4_1;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] req;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rr_arb_4_1_if if_h2 ();
  rr_arb_4_1_if if_h4 ();
  rr_arb_4_1_if if_h1 ();

  assign if_h2.req = req;
  assign if_h4.req = req;
  assign if_h1.req = req;

  rr_arb_4_1 #(.MAX_HOLD(2), .CNT_W(4)) u_h2 (.CLK(clk), .RST(rst), .bus(if_h2));
  rr_arb_4_1 #(.MAX_HOLD(4), .CNT_W(4)) u_h4 (.CLK(clk), .RST(rst), .bus(if_h4));
  rr_arb_4_1 #(.MAX_HOLD(1), .CNT_W(4)) u_h1 (.CLK(clk), .RST(rst), .bus(if_h1));

  typedef struct packed {
    logic [1:0] inst;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic [3:0] cnt;
    logic [1:0] ptr;
  } exp_t;

  exp_t sb_q[$];

  int         hold_lim [3] = '{2, 4, 1};
  logic       m_busy   [3];
  logic [1:0] m_ptr    [3];
  int         m_cnt    [3];
  logic [1:0] m_sel    [3];
  logic [3:0] m_gnt    [3];
  logic       m_valid  [3];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference pick: returns {found, index}.
  function automatic logic [2:0] ref_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    for (int k = 0; k < 4; k++) begin
      idx = p + k[1:0];
      if (r[idx]) return {1'b1, idx};
    end
    return 3'b000;
  endfunction

  task automatic model_grant(input int i, input logic [1:0] w);
    m_busy[i]  = 1'b1;
    m_gnt[i]   = 4'b0001 << w;
    m_sel[i]   = w;
    m_valid[i] = 1'b1;
    m_cnt[i]   = 1;
  endtask

  task automatic model_step(input int i);
    logic [2:0] pk;
    exp_t e;
    if (rst) begin
      m_busy[i] = 1'b0; m_ptr[i] = 2'd0; m_cnt[i] = 0;
      m_gnt[i] = 4'b0000; m_sel[i] = 2'd0; m_valid[i] = 1'b0;
    end else if (!m_busy[i]) begin
      pk = ref_pick(req, m_ptr[i]);
      if (pk[2]) model_grant(i, pk[1:0]);
    end else if (req[m_sel[i]] && m_cnt[i] < hold_lim[i]) begin
      m_cnt[i] = m_cnt[i] + 1;
    end else begin
      m_ptr[i] = m_sel[i] + 2'd1;
      pk = ref_pick(req, m_ptr[i]);
      if (pk[2]) begin
        model_grant(i, pk[1:0]);
      end else begin
        m_busy[i] = 1'b0; m_gnt[i] = 4'b0000; m_valid[i] = 1'b0; m_cnt[i] = 0;
      end
    end
    e.inst = i[1:0]; e.gnt = m_gnt[i]; e.sel = m_sel[i]; e.valid = m_valid[i];
    e.cnt = m_cnt[i][3:0]; e.ptr = m_ptr[i];
    sb_q.push_back(e);
  endtask

  function automatic exp_t observe(input logic [1:0] i);
    exp_t o;
    o = '0;
    o.inst = i;
    case (i)
      2'd0: begin o.gnt = if_h2.gnt; o.sel = if_h2.sel; o.valid = if_h2.valid; o.cnt = u_h2.cnt; o.ptr = u_h2.ptr; end
      2'd1: begin o.gnt = if_h4.gnt; o.sel = if_h4.sel; o.valid = if_h4.valid; o.cnt = u_h4.cnt; o.ptr = u_h4.ptr; end
      default: begin o.gnt = if_h1.gnt; o.sel = if_h1.sel; o.valid = if_h1.valid; o.cnt = u_h1.cnt; o.ptr = u_h1.ptr; end
    endcase
    return o;
  endfunction

  // Drive one cycle of stimulus, predict, then compare after the edge.
  task automatic cycle(input logic r, input logic [3:0] rq);
    exp_t e;
    exp_t o;
    string pfx;
    @(negedge clk);
    rst = r;
    req = rq;
    for (int i = 0; i < 3; i++) model_step(i);
    @(posedge clk);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      o = observe(e.inst);
      pfx = $sformatf("h%0d", hold_lim[e.inst]);
      check_eq({pfx, "_gnt"},   32'(o.gnt),   32'(e.gnt));
      check_eq({pfx, "_sel"},   32'(o.sel),   32'(e.sel));
      check_eq({pfx, "_valid"}, 32'(o.valid), 32'(e.valid));
      check_eq({pfx, "_ptr"},   32'(o.ptr),   32'(e.ptr));
      if (e.valid) check_eq({pfx, "_cnt"}, 32'(o.cnt), 32'(e.cnt));
    end
  endtask

  int rr_seq [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
  int solo_cnt [5] = '{1, 2, 3, 4, 1};

  initial begin
    logic [3:0] rq;
    rst = 1'b1;
    req = 4'b0000;

    // Reset dominates requests; release with no requests stays idle.
    cycle(1'b1, 4'b1111);
    check_eq("rst_gnt",   32'(if_h4.gnt),   32'h0);
    check_eq("rst_sel",   32'(if_h4.sel),   32'h0);
    check_eq("rst_valid", 32'(if_h4.valid), 32'h0);
    cycle(1'b0, 4'b0000);
    cycle(1'b0, 4'b0000);
    check_eq("idle_valid", 32'(if_h4.valid), 32'h0);

    // Single requester C, then drop: SEL holds through idle.
    cycle(1'b0, 4'b0100);
    check_eq("single_gnt",   32'(if_h4.gnt),   32'h4);
    check_eq("single_sel",   32'(if_h4.sel),   32'h2);
    check_eq("single_valid", 32'(if_h4.valid), 32'h1);
    cycle(1'b0, 4'b0000);
    check_eq("drop_valid", 32'(if_h4.valid), 32'h0);
    check_eq("drop_sel",   32'(if_h4.sel),   32'h2);

    // Fairness with all requesting: MAX_HOLD=2 pairs, MAX_HOLD=1 rotates.
    cycle(1'b1, 4'b0000);
    for (int k = 0; k < 9; k++) begin
      cycle(1'b0, 4'b1111);
      check_eq($sformatf("rr_sel_%0d", k), 32'(if_h2.sel), 32'(rr_seq[k]));
      check_eq($sformatf("rr_valid_%0d", k), 32'(if_h2.valid), 32'h1);
      check_eq($sformatf("rot_sel_%0d", k), 32'(if_h1.sel), 32'(k % 4));
    end

    // Early release: B holds three cycles, then D takes over with PTR=2.
    cycle(1'b1, 4'b0000);
    for (int k = 0; k < 3; k++) cycle(1'b0, 4'b1010);
    check_eq("early_b_sel", 32'(if_h4.sel), 32'h1);
    check_eq("early_b_cnt", 32'(u_h4.cnt),  32'h3);
    cycle(1'b0, 4'b1000);
    check_eq("early_d_sel", 32'(if_h4.sel), 32'h3);
    check_eq("early_d_cnt", 32'(u_h4.cnt),  32'h1);
    check_eq("early_d_ptr", 32'(u_h4.ptr),  32'h2);

    // Solo timeout: A re-granted to itself, counter wraps 4 -> 1.
    cycle(1'b1, 4'b0000);
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, 4'b0001);
      check_eq($sformatf("solo_gnt_%0d", k), 32'(if_h4.gnt), 32'h1);
      check_eq($sformatf("solo_cnt_%0d", k), 32'(u_h4.cnt), 32'(solo_cnt[k]));
    end

    // Reset mid-grant while C owns the path; next grant goes to A.
    cycle(1'b1, 4'b0000);
    for (int k = 0; k < 8; k++) begin
      cycle(1'b0, 4'b1111);
      if (if_h2.sel == 2'd2) break;
    end
    check_eq("reach_c_grant", 32'(if_h2.sel), 32'h2);
    cycle(1'b1, 4'b1111);
    check_eq("midrst_gnt",   32'(if_h2.gnt),   32'h0);
    check_eq("midrst_valid", 32'(if_h2.valid), 32'h0);
    check_eq("midrst_ptr",   32'(u_h2.ptr),    32'h0);
    cycle(1'b0, 4'b1111);
    check_eq("post_rst_gnt", 32'(if_h2.gnt), 32'h1);

    // Random traffic with sticky requests and occasional reset.
    rq = 4'b0000;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 2) == 0) rq = 4'($urandom_range(0, 15));
      cycle($urandom_range(0, 39) == 0, rq);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
